event_window_sequencer: RTL
===========================

EVENT_WINDOW_SEQUENCER -- requirements
Module: event_window_sequencer

Interface
REQ-001 SHALL have parameter HI_LEVEL, default 16'h7FFF, signed output level for logic high.
REQ-002 SHALL have parameter LO_LEVEL, default 16'h0000, signed output level for logic low.
REQ-003 Clk  in  1  clock; all logic on rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 DataIn  in  16 signed  ADC sample.
REQ-006 Threshold  in  16 signed  pulse discriminator level.
REQ-007 Arm  in  1  start request; sampled only in IDLE.
REQ-008 Abort  in  1  cancel run; overrides Arm.
REQ-009 TrigIn  in  1  external run trigger; rising edge used.
REQ-010 TrigDelay  in  16 unsigned  cycles from trigger edge to first window.
REQ-011 WindowLen  in  32 unsigned  window length in cycles; 0 treated as 1.
REQ-012 NumWindows  in  16 unsigned  windows per run.
REQ-013 PulseMin / PulseMax  in  16 unsigned each  exclusive pulse-length bounds in cycles.
REQ-014 MinPulseCount  in  16 unsigned  qualified pulses for a window to be "bright".
REQ-015 VoteMin  in  16 unsigned  bright windows needed for a positive run result.
REQ-016 DataOutA  out  16 signed  HI_LEVEL if last run result positive, else LO_LEVEL.
REQ-017 DataOutB  out  16 signed  HI_LEVEL while Busy, else LO_LEVEL.
REQ-018 Busy  out  1  high in ARMED, DELAY, COUNT, EVAL.
REQ-019 Done  out  1  one-cycle pulse when a run completes normally.
REQ-020 BrightCount  out  16 unsigned  bright windows of last completed run.

Function
REQ-021 All config inputs (TrigDelay..VoteMin) SHALL be latched on the cycle Arm is accepted; later changes ignored until next run.
REQ-022 States: IDLE, ARMED, DELAY, COUNT, EVAL, DONE.
REQ-023 IDLE->ARMED on Arm=1; ARMED->DELAY on TrigIn rising edge (TrigIn registered once, edge = cur & ~prev).
REQ-024 DELAY SHALL last exactly latched TrigDelay cycles (0 = skip straight to COUNT next cycle).
REQ-025 COUNT SHALL run windows back-to-back, each exactly WindowLen cycles, no gap cycles.
REQ-026 Discriminator: Above = registered (DataIn > Threshold), one cycle latency; pulse length L = consecutive cycles Above=1.
REQ-027 Pulse qualifies iff PulseMin < L < PulseMax, evaluated on the cycle Above falls.
REQ-028 Pulse whose rising or falling edge is outside current window SHALL be discarded; pulse-length counter cleared at each window start; a pulse already high at window start is ignored.
REQ-029 Pulse and length counters SHALL saturate at 16'hFFFF, never wrap.
REQ-030 At window end: window bright iff pulse count >= MinPulseCount; bright counter incremented (saturating).
REQ-031 A qualified pulse ending on the last cycle of a window SHALL count in that window.
REQ-032 After NumWindows windows -> EVAL (1 cycle): result = (bright >= VoteMin); BrightCount, DataOutA updated -> DONE.
REQ-033 NumWindows=0 SHALL skip DELAY/COUNT after trigger: BrightCount=0, result = (VoteMin==0).
REQ-034 DONE SHALL assert Done for one cycle, then return to IDLE.
REQ-035 Abort=1 in any state SHALL go to IDLE next cycle; BrightCount/DataOutA retain previous run; no Done.
REQ-036 Arm while Busy SHALL be ignored.

Reset
REQ-037 Reset SHALL force IDLE, all counters 0, Busy=0, Done=0, BrightCount=0, DataOutA=LO_LEVEL, DataOutB=LO_LEVEL, registered TrigIn/Above=0.
REQ-038 Reset mid-run SHALL discard the run without Done.

Structure
REQ-039 State enum and HI/LO level defaults SHALL live in shared package event_counter_pkg.
REQ-040 Discriminator plus per-window pulse counting SHALL be sub-module pulse_window_counter (inputs: window-start, window-end strobes; output: window count).

Verification
REQ-041 WindowLen=100, NumWindows=4, PulseMin=2, PulseMax=8, MinPulseCount=3, VoteMin=2; 3 pulses of L=5 in windows 0,2 -> BrightCount=2, DataOutA=7FFF, one Done.
REQ-042 Pulses of L=2 and L=8 (bounds) -> not counted; L=3 and L=7 counted.
REQ-043 Pulse straddling window 0/1 boundary -> counted in neither window.
REQ-044 TrigDelay=10: first window starts exactly 11 cycles after TrigIn rising edge is registered; Busy/DataOutB high ARMED through EVAL.
REQ-045 Abort in window 2 -> IDLE next cycle, no Done, BrightCount keeps prior value; Arm during COUNT ignored.
REQ-046 NumWindows=0, VoteMin=0 -> Done 2 cycles after trigger edge, BrightCount=0, DataOutA=7FFF.

Source files
------------

// File: rtl/event_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : event_counter_pkg
// Description : Shared state encoding, output level defaults and helpers for
//               the event window sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package event_counter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_COUNT = 3'd3,
        ST_EVAL  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic signed [15:0] C_HI_LEVEL = 16'sh7FFF;
    localparam logic signed [15:0] C_LO_LEVEL = 16'sh0000;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/event_window_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : event_window_sequencer_if
// Description : Sample, control, configuration and result signals of the
//               event window sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface event_window_sequencer_if;

    logic signed [15:0] DataIn;
    logic signed [15:0] Threshold;
    logic               Arm;
    logic               Abort;
    logic               TrigIn;
    logic        [15:0] TrigDelay;
    logic        [31:0] WindowLen;
    logic        [15:0] NumWindows;
    logic        [15:0] PulseMin;
    logic        [15:0] PulseMax;
    logic        [15:0] MinPulseCount;
    logic        [15:0] VoteMin;
    logic signed [15:0] DataOutA;
    logic signed [15:0] DataOutB;
    logic               Busy;
    logic               Done;
    logic        [15:0] BrightCount;

    modport master (
        output DataIn, Threshold, Arm, Abort, TrigIn, TrigDelay, WindowLen,
               NumWindows, PulseMin, PulseMax, MinPulseCount, VoteMin,
        input  DataOutA, DataOutB, Busy, Done, BrightCount
    );

    modport slave (
        input  DataIn, Threshold, Arm, Abort, TrigIn, TrigDelay, WindowLen,
               NumWindows, PulseMin, PulseMax, MinPulseCount, VoteMin,
        output DataOutA, DataOutB, Busy, Done, BrightCount
    );

endinterface
`default_nettype wire

// File: rtl/pulse_window_counter.sv
`default_nettype none
// ============================================================================
// Module      : pulse_window_counter
// Description : Threshold discriminator and qualified-pulse counter for one
//               measurement window at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_window_counter
    import event_counter_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic signed [15:0] data_in,
    input  logic signed [15:0] threshold,
    input  logic               win_start,
    input  logic               win_end,
    input  logic        [15:0] pulse_min,
    input  logic        [15:0] pulse_max,
    output logic        [15:0] window_count
);

    logic        r_above;
    logic        r_above_d;
    logic        r_in_win;
    logic        r_valid;
    logic [15:0] r_len;
    logic [15:0] r_pulse_cnt;

    logic        w_active;
    logic        w_rise;
    logic        w_fall;
    logic        w_qual;
    logic [15:0] w_base;

    assign w_active = win_start | r_in_win;
    assign w_rise   = r_above & ~r_above_d;
    assign w_fall   = ~r_above & r_above_d;

    // A fall on the first window cycle belongs to a pulse that rose earlier.
    assign w_qual = w_active & ~win_start & w_fall & r_valid &
                    (r_len > pulse_min) & (r_len < pulse_max);

    assign w_base       = win_start ? 16'd0 : r_pulse_cnt;
    assign window_count = w_qual ? sat_inc16(w_base) : w_base;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_above     <= 1'b0;
            r_above_d   <= 1'b0;
            r_in_win    <= 1'b0;
            r_valid     <= 1'b0;
            r_len       <= 16'd0;
            r_pulse_cnt <= 16'd0;
        end else begin
            r_above   <= (data_in > threshold);
            r_above_d <= r_above;
            r_in_win  <= w_active & ~win_end;

            if (win_start && !w_rise)
                r_len <= 16'd0;
            else if (r_above)
                r_len <= w_rise ? 16'd1 : sat_inc16(r_len);
            else
                r_len <= 16'd0;

            // Only a pulse whose rising edge lies inside the window is tracked.
            if (w_rise)
                r_valid <= w_active;
            else if (win_start || w_fall)
                r_valid <= 1'b0;

            r_pulse_cnt <= window_count;
        end
    end

endmodule
`default_nettype wire

// File: rtl/event_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : event_window_sequencer
// Description : Triggered multi-window pulse counter with bright-window vote.
// Revision    : 1.0 - initial release
// ============================================================================
module event_window_sequencer
    import event_counter_pkg::*;
#(
    parameter logic signed [15:0] HI_LEVEL = C_HI_LEVEL,
    parameter logic signed [15:0] LO_LEVEL = C_LO_LEVEL
) (
    input  logic                    Clk,
    input  logic                    Reset,
    event_window_sequencer_if.slave bus
);

    state_t             r_state;
    logic               r_trig;
    logic               r_trig_d;
    logic        [15:0] r_cfg_trig_delay;
    logic        [31:0] r_cfg_win_len;
    logic        [15:0] r_cfg_num_windows;
    logic        [15:0] r_cfg_pulse_min;
    logic        [15:0] r_cfg_pulse_max;
    logic        [15:0] r_cfg_min_pulses;
    logic        [15:0] r_cfg_vote_min;
    logic        [15:0] r_delay_cnt;
    logic        [31:0] r_win_cyc;
    logic        [15:0] r_win_idx;
    logic        [15:0] r_bright;
    logic        [15:0] r_bright_count;
    logic signed [15:0] r_out_a;
    logic signed [15:0] r_out_b;
    logic               r_busy;
    logic               r_done;

    logic               w_trig_edge;
    logic        [31:0] w_win_last_cyc;
    logic               w_win_start;
    logic               w_win_end;
    logic        [15:0] w_window_count;

    assign w_trig_edge    = r_trig & ~r_trig_d;
    assign w_win_last_cyc = (r_cfg_win_len == 32'd0) ? 32'd0 : r_cfg_win_len - 32'd1;
    assign w_win_start    = (r_state == ST_COUNT) && (r_win_cyc == 32'd0);
    assign w_win_end      = (r_state == ST_COUNT) && (r_win_cyc == w_win_last_cyc);

    pulse_window_counter u_pulse_window_counter (
        .Clk          (Clk),
        .Reset        (Reset),
        .data_in      (bus.DataIn),
        .threshold    (bus.Threshold),
        .win_start    (w_win_start),
        .win_end      (w_win_end),
        .pulse_min    (r_cfg_pulse_min),
        .pulse_max    (r_cfg_pulse_max),
        .window_count (w_window_count)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state           <= ST_IDLE;
            r_trig            <= 1'b0;
            r_trig_d          <= 1'b0;
            r_cfg_trig_delay  <= 16'd0;
            r_cfg_win_len     <= 32'd0;
            r_cfg_num_windows <= 16'd0;
            r_cfg_pulse_min   <= 16'd0;
            r_cfg_pulse_max   <= 16'd0;
            r_cfg_min_pulses  <= 16'd0;
            r_cfg_vote_min    <= 16'd0;
            r_delay_cnt       <= 16'd0;
            r_win_cyc         <= 32'd0;
            r_win_idx         <= 16'd0;
            r_bright          <= 16'd0;
            r_bright_count    <= 16'd0;
            r_out_a           <= LO_LEVEL;
            r_out_b           <= LO_LEVEL;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
        end else begin
            r_trig   <= bus.TrigIn;
            r_trig_d <= r_trig;
            r_done   <= 1'b0;

            if (bus.Abort) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_out_b <= LO_LEVEL;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.Arm) begin
                            r_cfg_trig_delay  <= bus.TrigDelay;
                            r_cfg_win_len     <= bus.WindowLen;
                            r_cfg_num_windows <= bus.NumWindows;
                            r_cfg_pulse_min   <= bus.PulseMin;
                            r_cfg_pulse_max   <= bus.PulseMax;
                            r_cfg_min_pulses  <= bus.MinPulseCount;
                            r_cfg_vote_min    <= bus.VoteMin;
                            r_busy            <= 1'b1;
                            r_out_b           <= HI_LEVEL;
                            r_state           <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (w_trig_edge) begin
                            r_win_cyc <= 32'd0;
                            r_win_idx <= 16'd0;
                            r_bright  <= 16'd0;
                            if (r_cfg_num_windows == 16'd0) begin
                                r_state <= ST_EVAL;
                            end else if (r_cfg_trig_delay == 16'd0) begin
                                r_state <= ST_COUNT;
                            end else begin
                                r_delay_cnt <= r_cfg_trig_delay;
                                r_state     <= ST_DELAY;
                            end
                        end
                    end
                    ST_DELAY: begin
                        if (r_delay_cnt == 16'd1)
                            r_state <= ST_COUNT;
                        else
                            r_delay_cnt <= r_delay_cnt - 16'd1;
                    end
                    ST_COUNT: begin
                        if (w_win_end) begin
                            r_win_cyc <= 32'd0;
                            if (w_window_count >= r_cfg_min_pulses)
                                r_bright <= sat_inc16(r_bright);
                            if (r_win_idx == r_cfg_num_windows - 16'd1)
                                r_state <= ST_EVAL;
                            else
                                r_win_idx <= r_win_idx + 16'd1;
                        end else begin
                            r_win_cyc <= r_win_cyc + 32'd1;
                        end
                    end
                    ST_EVAL: begin
                        r_bright_count <= r_bright;
                        r_out_a        <= (r_bright >= r_cfg_vote_min) ? HI_LEVEL : LO_LEVEL;
                        r_busy         <= 1'b0;
                        r_out_b        <= LO_LEVEL;
                        r_done         <= 1'b1;
                        r_state        <= ST_DONE;
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.DataOutA    = r_out_a;
    assign bus.DataOutB    = r_out_b;
    assign bus.Busy        = r_busy;
    assign bus.Done        = r_done;
    assign bus.BrightCount = r_bright_count;

endmodule
`default_nettype wire
